// File: rtl/iram_loader.sv
// Boot loader: assembles 24-bit words from a byte stream, writes them into the
// instruction RAM and verifies a trailing checksum while holding the core.
module iram_loader #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        load_active,
  output logic        cpu_hold,
  output logic        iram_we,
  output logic [7:0]  iram_addr,
  output logic [23:0] iram_data,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_B0   = 3'd2;
  localparam logic [2:0] S_B1   = 3'd3;
  localparam logic [2:0] S_B2   = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic [8:0]           idx_q, idx_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [7:0]           chk_q, chk_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [15:0]          word_q, word_d;
  logic                 we_q, we_d;
  logic [7:0]           addr_q, addr_d;
  logic [23:0]          data_q, data_d;
  logic                 busy;

  assign busy = (state_q == S_HDR) || (state_q == S_B0) || (state_q == S_B1) ||
                (state_q == S_B2)  || (state_q == S_CHK);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    tmo_d   = tmo_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    // Inter-byte watchdog; an accepted byte in the same cycle takes priority.
    if (busy) begin
      if (rx_valid)              tmo_d = '0;
      else if (tmo_q == TMO_LAST) state_d = S_ERR;
      else                       tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          idx_d   = '0;
          chk_d   = '0;
          tmo_d   = '0;
        end
      end
      S_HDR: if (rx_valid) begin
        cnt_d   = {(rx_data == 8'd0), rx_data};
        chk_d   = rx_data;
        state_d = S_B0;
      end
      S_B0: if (rx_valid) begin
        word_d[15:8] = rx_data;
        chk_d        = chk_q + rx_data;
        state_d      = S_B1;
      end
      S_B1: if (rx_valid) begin
        word_d[7:0] = rx_data;
        chk_d       = chk_q + rx_data;
        state_d     = S_B2;
      end
      S_B2: if (rx_valid) begin
        chk_d   = chk_q + rx_data;
        we_d    = 1'b1;
        addr_d  = idx_q[7:0];
        data_d  = {word_q, rx_data};
        idx_d   = idx_q + 9'd1;
        state_d = (idx_q == cnt_q - 9'd1) ? S_CHK : S_B0;
      end
      S_CHK: if (rx_valid) begin
        state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      tmo_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      tmo_q   <= tmo_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign load_active = busy;
  assign cpu_hold    = busy || (state_q == S_ERR);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign iram_we     = we_q;
  assign iram_addr   = addr_q;
  assign iram_data   = data_q;

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: vector table for short frames plus
// hand-written sequences for the full 256-word load, timeout and mid-load reset.
module tb_iram_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        load_active, cpu_hold, iram_we, done, error;
  logic [7:0]  iram_addr;
  logic [23:0] iram_data;

  int total = 0;
  int bad   = 0;

  iram_loader #(.TIMEOUT_CYCLES(16), .TIMEOUT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .load_active(load_active), .cpu_hold(cpu_hold), .iram_we(iram_we),
    .iram_addr(iram_addr), .iram_data(iram_data), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [7:0]  a;
    logic [23:0] wd;
    logic [3:0]  fl;   // {load_active, cpu_hold, done, error}
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic st, input logic v, input logic [7:0] d,
                      input logic we, input logic [7:0] a, input logic [23:0] wd,
                      input logic [3:0] fl);
    vec_t e;
    e.st = st; e.v = v; e.d = d; e.we = we; e.a = a; e.wd = wd; e.fl = fl;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs for one cycle and sample just after the active edge.
  task automatic tick(input logic st, input logic v, input logic [7:0] d);
    @(negedge clk);
    start = st; rx_valid = v; rx_data = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {load_active, cpu_hold, done, error};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    logic [7:0] sum;
    logic [7:0] b;
    logic [23:0] exp_w;

    // Idle pulses, then a good frame, then the same frame with a bad checksum.
    push(0,1,8'hAB, 0,8'h00,24'h000000,4'b0000);
    push(0,1,8'hCD, 0,8'h00,24'h000000,4'b0000);
    push(1,0,8'h00, 0,8'h00,24'h000000,4'b1100);
    push(0,1,8'h02, 0,8'h00,24'h000000,4'b1100);
    push(0,1,8'h11, 0,8'h00,24'h000000,4'b1100);
    push(0,1,8'h22, 0,8'h00,24'h000000,4'b1100);
    push(0,1,8'h33, 1,8'h00,24'h112233,4'b1100);
    push(0,1,8'h44, 0,8'h00,24'h112233,4'b1100);
    push(0,1,8'h55, 0,8'h00,24'h112233,4'b1100);
    push(0,1,8'h66, 1,8'h01,24'h445566,4'b1100);
    push(0,1,8'h67, 0,8'h01,24'h445566,4'b0010);
    push(0,1,8'h99, 0,8'h01,24'h445566,4'b0010);
    push(1,0,8'h00, 0,8'h01,24'h445566,4'b1100);
    push(0,1,8'h02, 0,8'h01,24'h445566,4'b1100);
    push(1,1,8'h11, 0,8'h01,24'h445566,4'b1100);
    push(0,1,8'h22, 0,8'h01,24'h445566,4'b1100);
    push(0,1,8'h33, 1,8'h00,24'h112233,4'b1100);
    push(0,1,8'h44, 0,8'h00,24'h112233,4'b1100);
    push(0,1,8'h55, 0,8'h00,24'h112233,4'b1100);
    push(0,1,8'h66, 1,8'h01,24'h445566,4'b1100);
    push(0,1,8'h68, 0,8'h01,24'h445566,4'b0101);
    push(0,1,8'hAA, 0,8'h01,24'h445566,4'b0101);

    // Reset for two cycles.
    tick(0,0,8'h00);
    tick(0,0,8'h00);
    check("reset_outputs", {iram_we, iram_addr, iram_data, flags()}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].st, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d", i), {iram_we, iram_addr, iram_data, flags()},
            {vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].fl});
    end
    tick(0,0,8'h00);

    // Full 256-word load, bytes back to back (one lands in each write cycle).
    tick(1,0,8'h00);
    tick(0,1,8'h00);
    sum = 8'h00;
    wcount = 0;
    for (int k = 0; k < 768; k++) begin
      b = 8'((k * 7 + 3) & 255);
      sum = sum + b;
      tick(0,1,b);
      if (iram_we) begin
        exp_w = {8'((3*wcount*7 + 3) & 255), 8'((3*wcount*7 + 10) & 255),
                 8'((3*wcount*7 + 17) & 255)};
        if (iram_addr !== 8'(wcount) || iram_data !== exp_w)
          check($sformatf("n256_word%0d", wcount), {iram_addr, iram_data},
                {8'(wcount), exp_w});
        wcount++;
      end
    end
    tick(0,1,sum);
    check("n256_writes", 64'(wcount), 64'd256);
    check("n256_last_addr", {56'h0, iram_addr}, 64'hFF);
    check("n256_flags", {60'h0, flags()}, {60'h0, 4'b0010});
    // Write pulses never last two cycles: bytes arrive every cycle, a word every third.
    check("n256_we_pulse", {63'h0, iram_we}, 64'h0);

    // Timeout: header 02, one word plus one byte, then silence.
    tick(1,0,8'h00);
    tick(0,1,8'h02);
    wcount = 0;
    for (int k = 0; k < 4; k++) begin
      tick(0,1,8'h11 * 8'(k + 1));
      if (iram_we) wcount++;
    end
    check("tmo_word", {iram_addr, iram_data}, {8'h00, 24'h112233});
    for (int k = 1; k <= 16; k++) begin
      tick(0,0,8'h00);
      if (iram_we) wcount++;
      if (k == 15) check("tmo_not_yet", {60'h0, flags()}, {60'h0, 4'b1100});
    end
    check("tmo_error", {60'h0, flags()}, {60'h0, 4'b0101});
    check("tmo_writes", 64'(wcount), 64'd1);

    // Reset in the middle of a word, then a clean restart.
    tick(1,0,8'h00);
    tick(0,1,8'h02);
    tick(0,1,8'h11);
    tick(0,1,8'h22);
    rst = 1'b1;
    tick(0,1,8'h33);
    check("rst_mid", {iram_we, flags()}, 64'h0);
    rst = 1'b0;
    tick(1,0,8'h00);
    check("restart_flags", {60'h0, flags()}, {60'h0, 4'b1100});
    wcount = 0;
    begin
      logic [7:0] fr [8];
      fr = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h67};
      for (int k = 0; k < 8; k++) begin
        tick(0,1,fr[k]);
        if (iram_we) begin
          check($sformatf("restart_w%0d", wcount), {iram_addr, iram_data},
                (wcount == 0) ? {8'h00, 24'h112233} : {8'h01, 24'h445566});
          wcount++;
        end
      end
    end
    check("restart_writes", 64'(wcount), 64'd2);
    check("restart_done", {60'h0, flags()}, {60'h0, 4'b0010});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
